// File: rtl/divider.sv
// Sequential WIDTH-bit integer divider (MIPS div/divu): restoring shift-subtract on
// magnitudes, one quotient bit per clock, then a single sign fix-up cycle.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       state_dbg
);

    // Handshake: start is sampled only in IDLE (ignored while busy); the request is
    // accepted on that edge, busy rises, and done pulses high for exactly one cycle
    // once hi/lo hold the new result. A start seen in the done cycle is accepted.

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   rem_sh, diff;

    always_comb begin
        sign1 = is_signed & operand1[WIDTH-1];
        sign2 = is_signed & operand2[WIDTH-1];
        mag1  = sign1 ? -operand1 : operand1;
        mag2  = sign2 ? -operand2 : operand2;
        // rem < divisor always holds, so one extra bit suffices for the shifted value.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_neg_d    = sign1 ^ sign2;
                    r_neg_d    = sign1;
                    rem_d      = '0;
                    dvs_d      = mag2;
                    count_d    = CW'(WIDTH);
                    busy_d     = 1'b1;
                    div_zero_d = 1'b0;
                    if (operand2 == '0) begin
                        // Keep the raw dividend: it becomes hi on divide-by-zero.
                        dz_d    = 1'b1;
                        quo_d   = operand1;
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        quo_d   = mag1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    hi_d       = quo_q;
                    lo_d       = '1;
                    div_zero_d = 1'b1;
                end else begin
                    hi_d = r_neg_q ? -rem_q : rem_q;
                    lo_d = q_neg_q ? -quo_q : quo_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider: table of hand-computed div/divu results plus
// sequences for ignored start, mid-run reset and back-to-back starts.
module tb_divider;

    logic        clock;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    divider #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .operand1  (operand1),
        .operand2  (operand2),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: called at a negedge; request is captured on the next posedge
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        is_signed = s;
        operand1  = a;
        operand2  = b;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        is_signed = 1'($urandom_range(0, 1));
        operand1  = $urandom;
        operand2  = $urandom;
    endtask

    // waits for done; lat = edges after the accepting edge; held = hi/lo stayed put
    task automatic wait_done(input logic [31:0] old_hi, input logic [31:0] old_lo,
                             output int lat, output logic held);
        lat  = 0;
        held = 1'b1;
        while (!done && lat < 60) begin
            if (hi !== old_hi || lo !== old_lo) held = 1'b0;
            @(negedge clock);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic        held;
        logic        saw_done;
        logic [31:0] old_hi, old_lo;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[5]  = '{1'b0, 32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234,       1'b1};
        vecs[6]  = '{1'b0, 32'h10,         32'd3,          32'd5,          32'd1,          1'b0};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0};
        vecs[9]  = '{1'b1, 32'h80000000,   32'd0,          32'hFFFFFFFF,   32'h80000000,   1'b1};
        vecs[10] = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5,          1'b0};
        vecs[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; operand1 = '0; operand2 = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dz", 32'(div_zero), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);

        // table of vectors
        for (int i = 0; i < 12; i++) begin
            old_hi = hi;
            old_lo = lo;
            issue(vecs[i].s, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            wait_done(old_hi, old_lo, lat, held);
            check($sformatf("v%0d_latency", i), 32'(lat), (vecs[i].b == 32'd0) ? 32'd1 : 32'd33);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_dz", i), 32'(div_zero), 32'(vecs[i].exp_dz));
            check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_hold", i), 32'(held), 32'd1);
            @(negedge clock);
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // start while busy is ignored
        old_hi = hi;
        old_lo = lo;
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clock);
        issue(1'b0, 32'd9, 32'd3);
        wait_done(old_hi, old_lo, lat, held);
        check("ign_latency", 32'(lat + 10), 32'd33);
        check("ign_lo", lo, 32'd14);
        check("ign_hi", hi, 32'd2);

        // reset mid-operation
        @(negedge clock);
        issue(1'b0, 32'd1000, 32'd3);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);

        // back-to-back: second start in the done cycle
        issue(1'b0, 32'd100, 32'd7);
        wait_done(32'd0, 32'd0, lat, held);
        check("b2b_first_lo", lo, 32'd14);
        issue(1'b0, 32'd1000, 32'd10);
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(32'd2, 32'd14, lat, held);
        check("b2b_latency", 32'(lat), 32'd33);
        check("b2b_hold", 32'(held), 32'd1);
        check("b2b_lo", lo, 32'd100);
        check("b2b_hi", hi, 32'd0);

        // div_zero cleared by next accepted start
        @(negedge clock);
        issue(1'b0, 32'd1234, 32'd0);
        wait_done(hi, lo, lat, held);
        check("dz_set", 32'(div_zero), 32'd1);
        @(negedge clock);
        issue(1'b0, 32'd9, 32'd3);
        check("dz_clear", 32'(div_zero), 32'd0);
        wait_done(32'd1234, 32'hFFFFFFFF, lat, held);
        check("dz_next_lo", lo, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential 32-bit integer divider: the inverse of the datapath's multiplier, sharing the same hi/lo result convention.
- Computes quotient into lo and remainder into hi, MIPS div/divu semantics, one quotient bit per clock (restoring shift-subtract on magnitudes) plus sign fix-up.
- Sits beside the multiplier in the execute stage; the control unit pulses start and waits on done.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state and outputs
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = div (two's complement), 0 = divu; captured with start
- operand1  input  WIDTH  dividend, captured on accepted start
- operand2  input  WIDTH  divisor, captured on accepted start
- hi  output  WIDTH  remainder, registered
- lo  output  WIDTH  quotient, registered
- busy  output  1  high while a division is in progress
- done  output  1  single-cycle pulse, hi/lo valid
- div_zero  output  1  set with done when divisor was zero; cleared on next accepted start

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
- States: IDLE, RUN, FIX.
- IDLE: on edge with start=1, latch operand magnitudes (negate if is_signed and MSB=1), quotient sign = sign1 XOR sign2, remainder sign = sign1; clear remainder accumulator; counter=WIDTH; busy=1; div_zero=0; go RUN. If operand2==0 go FIX directly, flagging divide-by-zero.
- RUN: each edge shift {rem, dividend} left 1; if rem >= |divisor| subtract and set quotient LSB=1, else 0; decrement counter; after WIDTH edges go FIX.
- FIX: one edge; apply signs (quotient negated if quotient sign, remainder negated if remainder sign); write hi/lo; done=1 for exactly that following cycle; busy=0; go IDLE.
- Latency: start accepted at edge 0 -> done and new hi/lo visible after edge WIDTH+1 (33 for default). Divide-by-zero: visible after edge 1.
- Divide by zero: lo=all ones, hi=operand1 (original, unsigned-interpreted value), div_zero=1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no flag.
- Remainder is 0 or takes dividend sign; |hi| < |divisor|.
- hi/lo hold last result until next FIX; not modified during RUN.
- start while busy: ignored, no effect on running operation or captured operands.
- start in the cycle done is high: accepted (state is IDLE); done drops next cycle.
- reset mid-operation: aborts immediately, all outputs return to reset values on that edge.
- Operands may change after capture without affecting the result.

Test Plan:
- divu 100 / 7, start one cycle -> busy for 33 cycles, done pulse after edge 33, lo=14, hi=2, div_zero=0.
- div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div 7 / 0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; divu 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0.
- divu 1234 / 0 -> done after edge 1, div_zero=1, lo=0xFFFFFFFF, hi=1234; next valid start clears div_zero.
- start 100/7, re-pulse start with 9/3 at cycle 10, then reset at cycle 20 -> second start ignored; reset clears busy/hi/lo to 0, no done pulse.
- Back-to-back: second start asserted in done cycle -> second result after 33 further edges, first result held on hi/lo until then.
